// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    StPllRst   = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRun      = 3'd3,
    StFail     = 3'd4
  } seq_state_e;

  localparam logic [7:0] LostCountMax = 8'hFF;

  // Width of a counter that must hold the largest of three cycle counts without wrapping.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchroniser bringing a single asynchronous level into the local clock domain.
module bit_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives the PLL reset, qualifies lock, releases the system reset and re-sequences on lock loss.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = 10,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic       i_refclk,
  input  logic       i_rst,
  input  logic       i_locked,
  input  logic       i_restart,
  input  logic       i_clr_status,
  output logic       o_pll_rst,
  output logic       o_sys_rst,
  output logic       o_ready,
  output logic       o_fail,
  output logic [3:0] o_retry_count,
  output logic       o_lock_lost,
  output logic [7:0] o_lost_count
);

  localparam int unsigned CNT_W =
      cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);

  localparam logic [CNT_W-1:0] PulseLast   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]       RetryMax    = 4'(MAX_RETRIES);

  seq_state_e       r_state;
  seq_state_e       w_state_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;
  logic [3:0]       r_retry_count;
  logic [3:0]       w_retry_count_d;
  logic             r_lock_lost;
  logic             w_lock_lost_d;
  logic [7:0]       r_lost_count;
  logic [7:0]       w_lost_count_d;
  logic             r_pll_rst;
  logic             r_sys_rst;
  logic             r_ready;
  logic             r_fail;
  logic             w_locked_s;

  bit_sync2 u_lock_sync (
    .i_clk (i_refclk),
    .i_rst (i_rst),
    .i_d   (i_locked),
    .o_q   (w_locked_s)
  );

  always_comb begin
    w_state_d       = r_state;
    w_cnt_d         = r_cnt;
    w_retry_count_d = r_retry_count;
    w_lock_lost_d   = r_lock_lost;
    w_lost_count_d  = r_lost_count;

    if (i_restart) begin
      w_state_d       = StPllRst;
      w_cnt_d         = '0;
      w_retry_count_d = '0;
    end else begin
      unique case (r_state)
        StPllRst: begin
          if (r_cnt == PulseLast) begin
            w_state_d = StWaitLock;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + CNT_W'(1);
          end
        end
        StWaitLock: begin
          if (w_locked_s) begin
            w_state_d = StStable;
            w_cnt_d   = '0;
          end else if (r_cnt == TimeoutLast) begin
            w_cnt_d = '0;
            if (r_retry_count == RetryMax) begin
              w_state_d = StFail;
            end else begin
              w_state_d       = StPllRst;
              w_retry_count_d = r_retry_count + 4'd1;
            end
          end else begin
            w_cnt_d = r_cnt + CNT_W'(1);
          end
        end
        StStable: begin
          // Any dropout restarts the timeout window without consuming a retry.
          if (!w_locked_s) begin
            w_state_d = StWaitLock;
            w_cnt_d   = '0;
          end else if (r_cnt == StableLast) begin
            w_state_d = StRun;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + CNT_W'(1);
          end
        end
        StRun: begin
          if (!w_locked_s) begin
            w_state_d       = StPllRst;
            w_cnt_d         = '0;
            w_retry_count_d = '0;
            w_lock_lost_d   = 1'b1;
            if (r_lost_count != LostCountMax) w_lost_count_d = r_lost_count + 8'd1;
          end
        end
        StFail: begin
          w_state_d = StFail;
        end
        default: begin
          w_state_d = StPllRst;
          w_cnt_d   = '0;
        end
      endcase
    end

    if (i_clr_status) begin
      w_lock_lost_d  = 1'b0;
      w_lost_count_d = '0;
    end
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge i_refclk) begin
    if (i_rst) begin
      r_state       <= StPllRst;
      r_cnt         <= '0;
      r_retry_count <= '0;
      r_lock_lost   <= 1'b0;
      r_lost_count  <= '0;
      r_pll_rst     <= 1'b1;
      r_sys_rst     <= 1'b1;
      r_ready       <= 1'b0;
      r_fail        <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_cnt         <= w_cnt_d;
      r_retry_count <= w_retry_count_d;
      r_lock_lost   <= w_lock_lost_d;
      r_lost_count  <= w_lost_count_d;
      r_pll_rst     <= (w_state_d == StPllRst);
      r_sys_rst     <= (w_state_d != StRun);
      r_ready       <= (w_state_d == StRun);
      r_fail        <= (w_state_d == StFail);
    end
  end

  assign o_pll_rst     = r_pll_rst;
  assign o_sys_rst     = r_sys_rst;
  assign o_ready       = r_ready;
  assign o_fail        = r_fail;
  assign o_retry_count = r_retry_count;
  assign o_lock_lost   = r_lock_lost;
  assign o_lost_count  = r_lost_count;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench: vector table, directed corner sequences and random traffic vs a phase model.
module tb_pll_reset_sequencer;

  localparam int unsigned PULSE   = 4;
  localparam int unsigned TIMEOUT = 20;
  localparam int unsigned STABLE  = 8;
  localparam int unsigned MAXR    = 2;

  localparam int P_PULSE = 0;
  localparam int P_WAIT  = 1;
  localparam int P_QUAL  = 2;
  localparam int P_RUN   = 3;
  localparam int P_DEAD  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       restart = 1'b0;
  logic       clr = 1'b0;
  logic       pll_rst, sys_rst, ready, fail, lock_lost;
  logic [3:0] retry_count;
  logic [7:0] lost_count;
  logic [16:0] obs;

  int n_tests = 0;
  int n_fail  = 0;

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES    (PULSE),
    .LOCK_TIMEOUT_CYCLES (TIMEOUT),
    .LOCK_STABLE_CYCLES  (STABLE),
    .MAX_RETRIES         (MAXR)
  ) dut (
    .i_refclk      (clk),
    .i_rst         (rst),
    .i_locked      (locked),
    .i_restart     (restart),
    .i_clr_status  (clr),
    .o_pll_rst     (pll_rst),
    .o_sys_rst     (sys_rst),
    .o_ready       (ready),
    .o_fail        (fail),
    .o_retry_count (retry_count),
    .o_lock_lost   (lock_lost),
    .o_lost_count  (lost_count)
  );

  always #5 clk = ~clk;

  assign obs = {pll_rst, sys_rst, ready, fail, retry_count, lock_lost, lost_count};

  function automatic logic [16:0] pk(input bit p, input bit s, input bit r, input bit f,
                                     input int t, input bit ll, input int lc);
    return {p, s, r, f, 4'(t), ll, 8'(lc)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase + time-in-phase, lock seen through a two-sample delay line.
  int m_phase, m_age, m_tries, m_lost_n;
  bit m_lost;
  bit m_valid = 1'b0;
  bit m_q[$];

  function automatic void model_step();
    bit ls;
    if (rst) begin
      m_phase = P_PULSE; m_age = 0; m_tries = 0; m_lost = 0; m_lost_n = 0;
      m_q = {1'b0, 1'b0};
      m_valid = 1'b1;
      return;
    end
    ls = m_q.pop_front();
    m_q.push_back(locked);
    if (restart) begin
      m_phase = P_PULSE; m_age = 0; m_tries = 0;
    end else begin
      case (m_phase)
        P_PULSE: begin
          m_age++;
          if (m_age == PULSE) begin m_phase = P_WAIT; m_age = 0; end
        end
        P_WAIT: begin
          if (ls) begin
            m_phase = P_QUAL; m_age = 0;
          end else begin
            m_age++;
            if (m_age == TIMEOUT) begin
              m_age = 0;
              if (m_tries == MAXR) m_phase = P_DEAD;
              else begin m_tries++; m_phase = P_PULSE; end
            end
          end
        end
        P_QUAL: begin
          if (!ls) begin
            m_phase = P_WAIT; m_age = 0;
          end else begin
            m_age++;
            if (m_age == STABLE) begin m_phase = P_RUN; m_age = 0; end
          end
        end
        P_RUN: begin
          if (!ls) begin
            m_lost = 1; m_lost_n = (m_lost_n >= 255) ? 255 : m_lost_n + 1;
            m_tries = 0; m_phase = P_PULSE; m_age = 0;
          end
        end
        default: ;
      endcase
    end
    if (clr) begin m_lost = 0; m_lost_n = 0; end
  endfunction

  function automatic logic [16:0] model_vec();
    return pk(m_phase == P_PULSE, m_phase != P_RUN, m_phase == P_RUN, m_phase == P_DEAD,
              m_tries, m_lost, m_lost_n);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (m_valid) check("model", 32'(obs), 32'(model_vec()));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_ready(input int bound, output int n, output int max_retry,
                            output int pll_seen);
    n = 0; max_retry = 0; pll_seen = 0;
    while (!ready && n < bound) begin
      tick();
      n++;
      if (int'(retry_count) > max_retry) max_retry = int'(retry_count);
      if (pll_rst) pll_seen++;
    end
    if (!ready) check("wait_ready_timeout", 32'(ready), 32'd1);
  endtask

  task automatic lose_lock();
    int n, mr, ps;
    locked = 1'b0;
    tick();
    locked = 1'b1;
    tick();
    tick();
    wait_ready(60, n, mr, ps);
  endtask

  typedef struct {
    bit          rst, lk, rs, clr;
    int          n;
    logic [16:0] exp;
  } vec_t;

  function automatic vec_t mk(input bit r, input bit l, input bit rs, input bit c, input int n,
                              input logic [16:0] e);
    vec_t v;
    v.rst = r; v.lk = l; v.rs = rs; v.clr = c; v.n = n; v.exp = e;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    int n, mr, ps, highs, maxr;

    // Nominal bring-up, one RUN lock loss, status clear, reset mid-qualification, restart.
    tbl.push_back(mk(1, 1, 0, 0, 3, pk(1, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(0, 1, 0, 0, 3, pk(1, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(0, 1, 0, 0, 1, pk(0, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(0, 1, 0, 0, 8, pk(0, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(0, 1, 0, 0, 1, pk(0, 0, 1, 0, 0, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 0, 1, pk(0, 0, 1, 0, 0, 0, 0)));
    tbl.push_back(mk(0, 1, 0, 0, 1, pk(0, 0, 1, 0, 0, 0, 0)));
    tbl.push_back(mk(0, 1, 0, 0, 1, pk(1, 1, 0, 0, 0, 1, 1)));
    tbl.push_back(mk(0, 1, 0, 0, 3, pk(1, 1, 0, 0, 0, 1, 1)));
    tbl.push_back(mk(0, 1, 0, 0, 1, pk(0, 1, 0, 0, 0, 1, 1)));
    tbl.push_back(mk(0, 1, 0, 1, 1, pk(0, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(0, 1, 0, 0, 7, pk(0, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, 1, 0, 0, 1, pk(1, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(0, 1, 0, 0, 4, pk(0, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(0, 1, 1, 0, 1, pk(1, 1, 0, 0, 0, 0, 0)));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; locked = tbl[i].lk; restart = tbl[i].rs; clr = tbl[i].clr;
      for (int k = 0; k < tbl[i].n; k++) tick();
      check($sformatf("vec%0d", i), 32'(obs), 32'(tbl[i].exp));
    end
    restart = 1'b0; clr = 1'b0;

    // Lock never arrives: three pulses, then FAIL until restart.
    locked = 1'b0;
    do_reset();
    n = 0; highs = 0; maxr = 0;
    while (!fail && n < 200) begin
      tick();
      n++;
      if (pll_rst) highs++;
      if (int'(retry_count) > maxr) maxr = int'(retry_count);
    end
    check("t2_edges_to_fail", 32'(n), 32'd72);
    check("t2_pll_rst_high_cycles", 32'(highs), 32'd11);
    check("t2_max_retry", 32'(maxr), 32'd2);
    for (int k = 0; k < 5; k++) tick();
    check("t2_fail_hold", 32'({fail, pll_rst, sys_rst, retry_count}), 32'({1'b1, 1'b0, 1'b1, 4'd2}));
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("t2_restart", 32'({fail, pll_rst, retry_count}), 32'({1'b0, 1'b1, 4'd0}));

    // One-cycle dropout during qualification restarts the stable window.
    locked = 1'b1;
    do_reset();
    for (int k = 0; k < 7; k++) tick();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    wait_ready(60, n, mr, ps);
    check("t4_edges_to_ready", 32'(8 + n), 32'd19);
    check("t4_retry_unchanged", 32'(mr), 32'd0);
    check("t4_no_pll_pulse", 32'(ps), 32'd0);

    // Reset while running.
    do_reset();
    wait_ready(60, n, mr, ps);
    check("t6_first_ready", 32'(n), 32'd13);
    for (int k = 0; k < 3; k++) tick();
    rst = 1'b1;
    tick();
    check("t6_rst_in_run", 32'(obs), 32'(pk(1, 1, 0, 0, 0, 0, 0)));
    rst = 1'b0;
    wait_ready(60, n, mr, ps);
    check("t6_ready_again", 32'(n), 32'd13);

    // Saturating loss counter, then clear colliding with a loss.
    for (int k = 0; k < 255; k++) lose_lock();
    check("t5_count_255", 32'({lock_lost, lost_count}), 32'({1'b1, 8'd255}));
    lose_lock();
    check("t5_saturate", 32'(lost_count), 32'd255);
    locked = 1'b0;
    tick();
    locked = 1'b1;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t5_clear_wins", 32'({lock_lost, lost_count, pll_rst}), 32'({1'b0, 8'd0, 1'b1}));

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(39) == 0) locked = ~locked;
      restart = ($urandom_range(99) == 0);
      clr     = ($urandom_range(99) == 0);
      rst     = ($urandom_range(499) == 0);
      tick();
    end
    rst = 1'b0; restart = 1'b0; clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
